// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and helpers shared by the UART receiver and the future transmitter.
//   uart_state_t : deframing FSM states (IDLE, START, DATA, STOP)
//   UART_OVS     : oversampling factor of the receiver (fixed at 16)
//   baud_div()   : rounded clock divider for a given clock, baud and OVS
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_OVS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Rounded divide of clk_freq by (baud * ovs), never below 1.
   function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
      int d;
      d = (clk_freq + (baud * ovs) / 2) / (baud * ovs);
      if (d < 1) d = 1;
      return d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   tick  out high for one cycle when the counter wraps (always high if DIV=1)
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             cnt <= '0;
      else if (cnt == LAST)  cnt <= '0;
      else                   cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver, 16x oversampled, feeding the peripheral RX registers.
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   rx        in  asynchronous serial line, idle high
//   rx_data   out last correctly framed byte, held until the next good byte
//   rx_status out one-cycle pulse, rx_data has just been updated
//   frame_err out one-cycle pulse, stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int OVS      = UART_OVS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_status,
   output logic       frame_err
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD, OVS);

   logic        tick;
   logic [1:0]  sync;
   logic        rxs;
   logic        prev;     // rxs at the previous tick, for start-edge detection
   uart_state_t state;
   logic [3:0]  sc;
   logic [2:0]  bi;
   logic [7:0]  sh;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], rx};
   end

   assign rxs = sync[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         prev      <= 1'b1;
         sc        <= '0;
         bi        <= '0;
         sh        <= '0;
         rx_data   <= '0;
         rx_status <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Strobes default low so each one lasts exactly one clock.
         rx_status <= 1'b0;
         frame_err <= 1'b0;
         if (tick) begin
            // Tracked in every state: after a low stop bit prev stays 0 until
            // the line goes high, so a held-low break cannot retrigger.
            prev <= rxs;
            case (state)
               IDLE: begin
                  if (!rxs && prev) begin
                     state <= START;
                     sc    <= '0;
                  end
               end
               START: begin
                  if (sc == 4'd7) begin
                     if (!rxs) begin
                        state <= DATA;
                        sc    <= '0;
                        bi    <= '0;
                     end else begin
                        state <= IDLE;   // too short to be a start bit
                     end
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
               DATA: begin
                  sc <= sc + 4'd1;       // wraps 15 -> 0 at each bit centre
                  if (sc == 4'd15) begin
                     sh <= {rxs, sh[7:1]};
                     if (bi == 3'd7) state <= STOP;
                     else            bi    <= bi + 3'd1;
                  end
               end
               STOP: begin
                  sc <= sc + 4'd1;
                  if (sc == 4'd15) begin
                     if (rxs) begin
                        rx_data   <= sh;
                        rx_status <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
